// File: rtl/lc3b_types.sv
// Shared LC-3b types used by the fetch stage and its skid buffer.
//   lc3b_word        : 16-bit machine word
//   lc3b_fetch_state : fetch FSM states (FETCH / HOLD / DROP)
//   lc3b_if_id       : IF/ID pipeline record {valid, ir, pc, pc_plus2}
//   pc_inc           : next sequential PC (wraps mod 2^16)
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } lc3b_fetch_state;

    typedef struct packed {
        logic     valid;
        lc3b_word ir;
        lc3b_word pc;
        lc3b_word pc_plus2;
    } lc3b_if_id;

    function automatic lc3b_word pc_inc(input lc3b_word p);
        return p + 16'd2;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry skid register for the fetch stage. Captures a fetched
// instruction that arrived while decode was stalled.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture d (entry becomes valid); wins over clear
//   clear      : invalidate the entry
//   d          : record to capture (its valid bit is ignored)
//   q          : stored record
//   valid      : entry holds an instruction
module fetch_skid_buffer
    import lc3b_types::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      load,
    input  logic      clear,
    input  lc3b_if_id d,
    output lc3b_if_id q,
    output logic      valid
);

    lc3b_if_id entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry <= '0;
        end else if (load) begin
            entry       <= d;
            entry.valid <= 1'b1;
        end else if (clear) begin
            entry.valid <= 1'b0;
        end
    end

    assign q     = entry;
    assign valid = entry.valid;

endmodule

// File: rtl/fetch_stage.sv
// LC-3b instruction-fetch stage. Owns the PC, runs the I-cache read
// handshake, and holds the IF/ID register consumed by decode.
// Handshake: icache_read is held high with icache_address stable until the
// cycle icache_resp=1; that cycle completes the request (zero-wait allowed).
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   icache_read     : fetch request
//   icache_address  : byte address of the requested instruction
//   icache_resp     : single-cycle response strobe, icache_rdata valid
//   icache_rdata    : fetched instruction word
//   stall           : decode cannot accept, IF/ID holds
//   flush           : redirect taken, discard in-flight/buffered work
//   redirect_pc     : new fetch address, valid with flush
//   if_valid/if_ir/if_pc/if_pc_plus2 : IF/ID register
//   state           : current FSM state (debug visibility)
module fetch_stage
    import lc3b_types::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            icache_read,
    output logic [15:0]     icache_address,
    input  logic            icache_resp,
    input  logic [15:0]     icache_rdata,
    input  logic            stall,
    input  logic            flush,
    input  logic [15:0]     redirect_pc,
    output logic            if_valid,
    output logic [15:0]     if_ir,
    output logic [15:0]     if_pc,
    output logic [15:0]     if_pc_plus2,
    output lc3b_fetch_state state
);

    lc3b_fetch_state state_q, state_next;
    lc3b_word        pc, pc_next;
    lc3b_word        hold_addr, hold_next;
    lc3b_if_id       ifid, ifid_next;
    lc3b_if_id       skid_d, skid_q;
    logic            skid_load, skid_clear, skid_valid;
    logic            deliver;

    assign skid_d = '{valid: 1'b1, ir: icache_rdata, pc: pc, pc_plus2: pc_inc(pc)};

    fetch_skid_buffer u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (skid_d),
        .q     (skid_q),
        .valid (skid_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            pc        <= RESET_PC;
            hold_addr <= RESET_PC;
            ifid      <= '0;
        end else begin
            state_q   <= state_next;
            pc        <= pc_next;
            hold_addr <= hold_next;
            ifid      <= ifid_next;
        end
    end

    always_comb begin
        state_next = state_q;
        pc_next    = pc;
        hold_next  = hold_addr;
        ifid_next  = ifid;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        deliver    = 1'b0;

        case (state_q)
            FETCH: begin
                if (icache_resp) begin
                    if (flush) begin
                        pc_next = redirect_pc;
                    end else if (!stall) begin
                        ifid_next = skid_d;
                        deliver   = 1'b1;
                        pc_next   = pc_inc(pc);
                    end else begin
                        skid_load  = 1'b1;
                        pc_next    = pc_inc(pc);
                        state_next = HOLD;
                    end
                end else if (flush) begin
                    // The cache still owes us a response for pc; keep
                    // presenting that address until it arrives.
                    hold_next  = pc;
                    pc_next    = redirect_pc;
                    state_next = DROP;
                end
            end
            HOLD: begin
                if (flush) begin
                    skid_clear = 1'b1;
                    pc_next    = redirect_pc;
                    state_next = FETCH;
                end else if (!stall) begin
                    ifid_next       = skid_q;
                    ifid_next.valid = skid_valid;
                    deliver         = 1'b1;
                    skid_clear      = 1'b1;
                    state_next      = FETCH;
                end
            end
            DROP: begin
                if (flush) pc_next = redirect_pc;
                if (icache_resp) state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase

        // Flush beats stall; otherwise an unstalled cycle with nothing to
        // hand over becomes a bubble (other fields keep their old values).
        if (flush) begin
            ifid_next.valid = 1'b0;
        end else if (!stall && !deliver) begin
            ifid_next.valid = 1'b0;
        end
    end

    assign icache_read    = rst_n && (state_q != HOLD);
    assign icache_address = (state_q == DROP) ? hold_addr : pc;

    assign if_valid    = ifid.valid;
    assign if_ir       = ifid.ir;
    assign if_pc       = ifid.pc;
    assign if_pc_plus2 = ifid.pc_plus2;
    assign state       = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a table of per-cycle stimulus with
// hand-computed expectations, plus a reset-mid-request sequence.
module tb_fetch_stage;
    import lc3b_types::*;

    logic            clk;
    logic            rst_n;
    logic            icache_read;
    logic [15:0]     icache_address;
    logic            icache_resp;
    logic [15:0]     icache_rdata;
    logic            stall;
    logic            flush;
    logic [15:0]     redirect_pc;
    logic            if_valid;
    logic [15:0]     if_ir;
    logic [15:0]     if_pc;
    logic [15:0]     if_pc_plus2;
    lc3b_fetch_state state;

    int n_cmp  = 0;
    int n_fail = 0;

    fetch_stage #(.RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .icache_read    (icache_read),
        .icache_address (icache_address),
        .icache_resp    (icache_resp),
        .icache_rdata   (icache_rdata),
        .stall          (stall),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ir          (if_ir),
        .if_pc          (if_pc),
        .if_pc_plus2    (if_pc_plus2),
        .state          (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        resp;
        logic [15:0] rdata;
        logic        stall;
        logic        flush;
        logic [15:0] rpc;
        logic        e_read;   // before the edge
        logic [15:0] e_addr;   // checked only when e_read=1
        logic [1:0]  e_state;
        logic        e_valid;  // after the edge
        logic [15:0] e_ir;     // ir/pc checked only when e_valid=1
        logic [15:0] e_pc;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic resp, input logic [15:0] rdata, input logic st,
                       input logic fl, input logic [15:0] rpc, input logic e_read,
                       input logic [15:0] e_addr, input lc3b_fetch_state e_state,
                       input logic e_valid, input logic [15:0] e_ir, input logic [15:0] e_pc);
        vec_t v;
        v.resp = resp; v.rdata = rdata; v.stall = st; v.flush = fl; v.rpc = rpc;
        v.e_read = e_read; v.e_addr = e_addr; v.e_state = e_state;
        v.e_valid = e_valid; v.e_ir = e_ir; v.e_pc = e_pc;
        vq.push_back(v);
    endtask

    // driver: apply one cycle at the falling edge, check combinational
    // outputs before the rising edge and IF/ID after it
    task automatic apply(input vec_t v, input int idx);
        logic [15:0] exp_pc2;
        @(negedge clk);
        icache_resp  = v.resp;
        icache_rdata = v.rdata;
        stall        = v.stall;
        flush        = v.flush;
        redirect_pc  = v.rpc;
        #1;
        chk($sformatf("v%0d icache_read", idx), {31'd0, icache_read}, {31'd0, v.e_read});
        if (v.e_read) chk($sformatf("v%0d icache_address", idx), {16'd0, icache_address}, {16'd0, v.e_addr});
        chk($sformatf("v%0d state", idx), {30'd0, state}, {30'd0, v.e_state});
        @(posedge clk);
        #1;
        chk($sformatf("v%0d if_valid", idx), {31'd0, if_valid}, {31'd0, v.e_valid});
        if (v.e_valid) begin
            exp_pc2 = v.e_pc + 16'd2;
            chk($sformatf("v%0d if_ir", idx), {16'd0, if_ir}, {16'd0, v.e_ir});
            chk($sformatf("v%0d if_pc", idx), {16'd0, if_pc}, {16'd0, v.e_pc});
            chk($sformatf("v%0d if_pc_plus2", idx), {16'd0, if_pc_plus2}, {16'd0, exp_pc2});
        end
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0; icache_resp = 1'b0; icache_rdata = '0;
        stall = 1'b0; flush = 1'b0; redirect_pc = '0;

        // streaming, zero-wait hits
        add(1, 16'h1234, 0, 0, 0,        1, 16'h0000, FETCH, 1, 16'h1234, 16'h0000);
        add(1, 16'hA002, 0, 0, 0,        1, 16'h0002, FETCH, 1, 16'hA002, 16'h0002);
        add(1, 16'hA004, 0, 0, 0,        1, 16'h0004, FETCH, 1, 16'hA004, 16'h0004);
        // stall for 4 cycles while the response at 0006 arrives
        add(1, 16'hB006, 1, 0, 0,        1, 16'h0006, FETCH, 1, 16'hA004, 16'h0004);
        add(0, 16'h0000, 1, 0, 0,        0, 16'h0000, HOLD,  1, 16'hA004, 16'h0004);
        add(0, 16'h0000, 1, 0, 0,        0, 16'h0000, HOLD,  1, 16'hA004, 16'h0004);
        add(0, 16'h0000, 1, 0, 0,        0, 16'h0000, HOLD,  1, 16'hA004, 16'h0004);
        add(0, 16'h0000, 0, 0, 0,        0, 16'h0000, HOLD,  1, 16'hB006, 16'h0006);
        // 3-cycle latency at 0008
        add(0, 16'h0000, 0, 0, 0,        1, 16'h0008, FETCH, 0, 16'h0000, 16'h0000);
        add(0, 16'h0000, 0, 0, 0,        1, 16'h0008, FETCH, 0, 16'h0000, 16'h0000);
        add(1, 16'hC008, 0, 0, 0,        1, 16'h0008, FETCH, 1, 16'hC008, 16'h0008);
        add(1, 16'hC00A, 0, 0, 0,        1, 16'h000A, FETCH, 1, 16'hC00A, 16'h000A);
        add(1, 16'hC00C, 0, 0, 0,        1, 16'h000C, FETCH, 1, 16'hC00C, 16'h000C);
        add(1, 16'hC00E, 0, 0, 0,        1, 16'h000E, FETCH, 1, 16'hC00E, 16'h000E);
        // flush to 3000 while the request to 0010 is pending
        add(0, 16'h0000, 0, 1, 16'h3000, 1, 16'h0010, FETCH, 0, 16'h0000, 16'h0000);
        add(0, 16'h0000, 0, 0, 0,        1, 16'h0010, DROP,  0, 16'h0000, 16'h0000);
        add(1, 16'hDEAD, 0, 0, 0,        1, 16'h0010, DROP,  0, 16'h0000, 16'h0000);
        add(1, 16'hD300, 0, 0, 0,        1, 16'h3000, FETCH, 1, 16'hD300, 16'h3000);
        // flush and stall together, with a response
        add(1, 16'hEEEE, 1, 1, 16'h4000, 1, 16'h3002, FETCH, 0, 16'h0000, 16'h0000);
        add(1, 16'hE400, 0, 0, 0,        1, 16'h4000, FETCH, 1, 16'hE400, 16'h4000);
        // flush in HOLD, redirect to FFFE
        add(1, 16'hE402, 1, 0, 0,        1, 16'h4002, FETCH, 1, 16'hE400, 16'h4000);
        add(0, 16'h0000, 1, 1, 16'hFFFE, 0, 16'h0000, HOLD,  0, 16'h0000, 16'h0000);
        // PC wrap
        add(1, 16'hF0FE, 0, 0, 0,        1, 16'hFFFE, FETCH, 1, 16'hF0FE, 16'hFFFE);
        add(1, 16'h0F00, 0, 0, 0,        1, 16'h0000, FETCH, 1, 16'h0F00, 16'h0000);
        // two flushes while dropping: latest target wins
        add(0, 16'h0000, 0, 1, 16'h5000, 1, 16'h0002, FETCH, 0, 16'h0000, 16'h0000);
        add(0, 16'h0000, 0, 1, 16'h6000, 1, 16'h0002, DROP,  0, 16'h0000, 16'h0000);
        add(1, 16'hBAD0, 0, 0, 0,        1, 16'h0002, DROP,  0, 16'h0000, 16'h0000);
        add(1, 16'h6666, 0, 0, 0,        1, 16'h6000, FETCH, 1, 16'h6666, 16'h6000);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset icache_read", {31'd0, icache_read}, 32'd0);
        chk("reset if_valid", {31'd0, if_valid}, 32'd0);
        chk("reset if_ir", {16'd0, if_ir}, 32'd0);
        chk("reset if_pc", {16'd0, if_pc}, 32'd0);
        chk("reset if_pc_plus2", {16'd0, if_pc_plus2}, 32'd0);
        chk("reset state", {30'd0, state}, {30'd0, FETCH});
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[i]) apply(vq[i], i);

        // reset asserted mid-request (request to 6002 outstanding)
        @(negedge clk);
        icache_resp = 1'b0; stall = 1'b0; flush = 1'b0;
        #1;
        chk("pre-reset icache_address", {16'd0, icache_address}, 32'h6002);
        rst_n = 1'b0;
        #1;
        chk("midreset icache_read", {31'd0, icache_read}, 32'd0);
        chk("midreset if_valid", {31'd0, if_valid}, 32'd0);
        chk("midreset if_pc", {16'd0, if_pc}, 32'd0);
        chk("midreset state", {30'd0, state}, {30'd0, FETCH});
        @(negedge clk);
        rst_n = 1'b1;
        v.resp = 1; v.rdata = 16'h7777; v.stall = 0; v.flush = 0; v.rpc = 0;
        v.e_read = 1; v.e_addr = 16'h0000; v.e_state = FETCH;
        v.e_valid = 1; v.e_ir = 16'h7777; v.e_pc = 16'h0000;
        apply(v, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
